// File: rtl/xvga_timing_rx.sv
// xvga_timing_rx: recovers raster position and frame geometry from an
// incoming active-low hsync/vsync plus blank stream.
//
// Ports
//   vclock            pixel clock (single domain)
//   reset_n           asynchronous active-low reset
//   hsync, vsync      active-low syncs
//   blank             high outside the active area
//   hcount, vcount    position, 0 at the first active pixel / line
//   active            current pixel visible (aligned with hcount)
//   frame_start       pulse on the first active pixel of a frame
//   locked            geometry stable for LOCK_FRAMES frames
//   error             one-cycle pulse on a timing violation
//   h_total, h_active measured clocks / active pixels per line
//   v_total, v_active measured lines / active lines per frame
// Every input sample reaches the outputs two cycles later.
module xvga_timing_rx #(
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 4095
) (
  input  logic        vclock,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        active,
  output logic        frame_start,
  output logic        locked,
  output logic        error,
  output logic [11:0] h_total,
  output logic [11:0] h_active,
  output logic [10:0] v_total,
  output logic [10:0] v_active
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [11:0] TIMEOUT_M1 = 12'(TIMEOUT - 1);
  localparam logic [7:0]  LOCK_M1    = 8'(LOCK_FRAMES - 1);

  logic hsync_q, hsync_qq, vsync_q, vsync_qq, blank_q, blank_qq;
  logic hs_assert_s, vs_assert_s, als_s, blank_rise_s;

  state_e      state_q, state_d;
  logic [11:0] line_cnt_q, line_cnt_d;
  logic [11:0] pix_cnt_q, pix_cnt_d;
  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        active_q, active_d;
  logic        frame_start_q, frame_start_d;
  logic        vs_pend_q, vs_pend_d;
  logic        locked_q, locked_d;
  logic        error_q, error_d;
  logic [11:0] h_total_q, h_total_d;
  logic [11:0] h_active_q, h_active_d;
  logic [10:0] v_total_q, v_total_d;
  logic [10:0] v_active_q, v_active_d;
  logic [10:0] hs_frm_q, hs_frm_d;
  logic [10:0] als_frm_q, als_frm_d;
  logic [7:0]  match_cnt_q, match_cnt_d;
  logic [11:0] line_ref_q, line_ref_d;
  logic        line_first_q, line_first_d;
  logic        frame_ok_q, frame_ok_d;
  logic        vref_valid_q, vref_valid_d;

  logic [10:0] hs_frm_s, als_frm_s;
  logic        frame_ok_s, frame_match_s, timeout_s, line_err_s;

  // Input sample and delay registers; idle (all high) out of reset so no false edges.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q  <= 1'b1;
      hsync_qq <= 1'b1;
      vsync_q  <= 1'b1;
      vsync_qq <= 1'b1;
      blank_q  <= 1'b1;
      blank_qq <= 1'b1;
    end else begin
      hsync_q  <= hsync;
      hsync_qq <= hsync_q;
      vsync_q  <= vsync;
      vsync_qq <= vsync_q;
      blank_q  <= blank;
      blank_qq <= blank_q;
    end
  end

  assign hs_assert_s  = hsync_qq & ~hsync_q;
  assign vs_assert_s  = vsync_qq & ~vsync_q;
  assign als_s        = blank_qq & ~blank_q;
  assign blank_rise_s = ~blank_qq & blank_q;

  // Next-state logic: counters, measurements and lock state machine.
  always_comb begin
    state_d       = state_q;
    line_cnt_d    = line_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    active_d      = ~blank_q;
    frame_start_d = 1'b0;
    vs_pend_d     = vs_pend_q;
    error_d       = 1'b0;
    h_total_d     = h_total_q;
    h_active_d    = h_active_q;
    v_total_d     = v_total_q;
    v_active_d    = v_active_q;
    hs_frm_d      = hs_frm_q;
    als_frm_d     = als_frm_q;
    match_cnt_d   = match_cnt_q;
    line_ref_d    = line_ref_q;
    line_first_d  = line_first_q;
    frame_ok_d    = frame_ok_q;
    vref_valid_d  = vref_valid_q;

    // Line counter and line-length capture.
    if (hs_assert_s) begin
      line_cnt_d = 12'd1;
      h_total_d  = line_cnt_q;
    end else if (line_cnt_q != 12'hFFF) begin
      line_cnt_d = line_cnt_q + 12'd1;
    end else begin
      line_cnt_d = line_cnt_q;
    end
    timeout_s  = !hs_assert_s && (line_cnt_q == TIMEOUT_M1);
    line_err_s = hs_assert_s && (line_cnt_q != h_total_q);

    // Per-frame line-length consistency; the first line of a frame sets the reference.
    frame_ok_s = frame_ok_q;
    if (hs_assert_s) begin
      if (line_first_q) begin
        line_ref_d   = line_cnt_q;
        line_first_d = 1'b0;
      end else if (line_cnt_q != line_ref_q) begin
        frame_ok_s = 1'b0;
      end else begin
        frame_ok_s = frame_ok_q;
      end
    end
    frame_ok_d = frame_ok_s;

    // Active pixels since the last active-line start.
    if (als_s) begin
      pix_cnt_d = 12'd1;
    end else if (!blank_q && pix_cnt_q != 12'hFFF) begin
      pix_cnt_d = pix_cnt_q + 12'd1;
    end else begin
      pix_cnt_d = pix_cnt_q;
    end
    if (blank_rise_s && vsync_q) begin
      h_active_d = pix_cnt_q;
    end

    // Raster position.
    if (als_s) begin
      hcount_d = 11'd0;
    end else if (hcount_q != 11'h7FF) begin
      hcount_d = hcount_q + 11'd1;
    end else begin
      hcount_d = hcount_q;
    end
    if (als_s) begin
      if (vs_pend_q) begin
        vcount_d      = 10'd0;
        frame_start_d = 1'b1;
        vs_pend_d     = 1'b0;
      end else if (vcount_q != 10'h3FF) begin
        vcount_d = vcount_q + 10'd1;
      end else begin
        vcount_d = vcount_q;
      end
    end

    // Frame counts include this cycle's hsync so a closing line belongs to the old frame.
    hs_frm_s  = (hs_assert_s && hs_frm_q != 11'h7FF) ? hs_frm_q + 11'd1 : hs_frm_q;
    als_frm_s = (als_s && als_frm_q != 11'h7FF) ? als_frm_q + 11'd1 : als_frm_q;
    frame_match_s = frame_ok_s && (!vref_valid_q || (hs_frm_s == v_total_q));
    if (vs_assert_s) begin
      vs_pend_d    = 1'b1;
      v_total_d    = hs_frm_s;
      v_active_d   = als_frm_s;
      hs_frm_d     = 11'd0;
      als_frm_d    = 11'd0;
      line_first_d = 1'b1;
      frame_ok_d   = 1'b1;
      // A frame that closes in SEARCH is partial and cannot serve as a reference.
      vref_valid_d = (state_q != SEARCH);
    end else begin
      hs_frm_d  = hs_frm_s;
      als_frm_d = als_frm_s;
    end

    case (state_q)
      SEARCH: begin
        if (vs_assert_s) begin
          state_d     = ACQUIRE;
          match_cnt_d = 8'd0;
        end
      end
      ACQUIRE: begin
        if (vs_assert_s) begin
          if (!frame_match_s) begin
            match_cnt_d = 8'd0;
          end else if (match_cnt_q >= LOCK_M1) begin
            state_d     = LOCKED;
            match_cnt_d = 8'd0;
          end else begin
            match_cnt_d = match_cnt_q + 8'd1;
          end
        end
      end
      LOCKED: begin
        if (line_err_s || (vs_assert_s && hs_frm_s != v_total_q)) begin
          error_d     = 1'b1;
          state_d     = ACQUIRE;
          match_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d     = SEARCH;
        match_cnt_d = 8'd0;
      end
    endcase

    if (timeout_s) begin
      error_d     = 1'b1;
      state_d     = SEARCH;
      match_cnt_d = 8'd0;
    end
    locked_d = (state_d == LOCKED);
  end

  // State and output registers.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SEARCH;
      line_cnt_q    <= 12'd0;
      pix_cnt_q     <= 12'd0;
      hcount_q      <= 11'd0;
      vcount_q      <= 10'd0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      vs_pend_q     <= 1'b0;
      locked_q      <= 1'b0;
      error_q       <= 1'b0;
      h_total_q     <= 12'd0;
      h_active_q    <= 12'd0;
      v_total_q     <= 11'd0;
      v_active_q    <= 11'd0;
      hs_frm_q      <= 11'd0;
      als_frm_q     <= 11'd0;
      match_cnt_q   <= 8'd0;
      line_ref_q    <= 12'd0;
      line_first_q  <= 1'b1;
      frame_ok_q    <= 1'b1;
      vref_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_cnt_q    <= line_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      vs_pend_q     <= vs_pend_d;
      locked_q      <= locked_d;
      error_q       <= error_d;
      h_total_q     <= h_total_d;
      h_active_q    <= h_active_d;
      v_total_q     <= v_total_d;
      v_active_q    <= v_active_d;
      hs_frm_q      <= hs_frm_d;
      als_frm_q     <= als_frm_d;
      match_cnt_q   <= match_cnt_d;
      line_ref_q    <= line_ref_d;
      line_first_q  <= line_first_d;
      frame_ok_q    <= frame_ok_d;
      vref_valid_q  <= vref_valid_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign error       = error_q;
  assign h_total     = h_total_q;
  assign h_active    = h_active_q;
  assign v_total     = v_total_q;
  assign v_active    = v_active_q;

endmodule

// File: tb/tb_xvga_timing_rx.sv
// Directed bench for xvga_timing_rx on a reduced raster (48x20 total,
// 32x12 active) so that many frames fit in a short run.
module tb_xvga_timing_rx;

  localparam int H_TOT  = 48;
  localparam int H_ACT  = 32;
  localparam int HS_BEG = 36;
  localparam int HS_END = 41;
  localparam int V_ACT  = 12;
  localparam int VS_BEG = 14;
  localparam int VS_END = 15;
  localparam int V_TOT0 = 20;
  localparam int V_TOT1 = 18;

  logic        vclock;
  logic        reset_n;
  logic        hsync, vsync, blank;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        active, frame_start, locked, error;
  logic [11:0] h_total, h_active;
  logic [10:0] v_total, v_active;

  xvga_timing_rx dut (
    .vclock(vclock), .reset_n(reset_n), .hsync(hsync), .vsync(vsync), .blank(blank),
    .hcount(hcount), .vcount(vcount), .active(active), .frame_start(frame_start),
    .locked(locked), .error(error), .h_total(h_total), .h_active(h_active),
    .v_total(v_total), .v_active(v_active)
  );

  initial vclock = 1'b0;
  always #5 vclock = ~vclock;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  sb_t e;
  logic [31:0] obs;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int err_cnt = 0, last_err_cyc = -1, fs_cnt = 0;
  int rise_cyc = -1, fall_cyc = -1;
  logic prev_locked = 1'b0;
  int vs_cyc = -1, last_hs_cyc = -1, glitch_cyc = -1;
  int rel_err = 0, rel_fs = 0;

  function automatic string kind_name(input int kind);
    case (kind)
      0: return "hcount";
      1: return "vcount";
      2: return "active";
      3: return "frame_start";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] obs_of(input int kind);
    case (kind)
      0: return {21'd0, hcount};
      1: return {22'd0, vcount};
      2: return {31'd0, active};
      3: return {31'd0, frame_start};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Scoreboard drain and event bookkeeping, away from the active edge.
  always @(negedge vclock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      obs = obs_of(e.kind);
      checks++;
      assert (e.due == cyc && obs === e.exp) else begin
        failures++;
        $error("FAIL %s cycle=%0d due=%0d observed=%0d expected=%0d",
               kind_name(e.kind), cyc, e.due, obs, e.exp);
      end
    end
    if (error === 1'b1) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (frame_start === 1'b1) fs_cnt++;
    if (locked === 1'b1 && prev_locked === 1'b0) rise_cyc = cyc;
    if (locked === 1'b0 && prev_locked === 1'b1) fall_cyc = cyc;
    prev_locked = locked;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, x);
    end
  endtask

  task automatic push(input int due, input int kind, input logic [31:0] x);
    sb.push_back('{due, kind, x});
  endtask

  task automatic tick(input logic hs, input logic vs, input logic bl);
    @(posedge vclock);
    #1;
    hsync = hs;
    vsync = vs;
    blank = bl;
    cyc++;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_hcount"}, {21'd0, hcount}, 32'd0);
    chk({tag, "_vcount"}, {22'd0, vcount}, 32'd0);
    chk({tag, "_active"}, {31'd0, active}, 32'd0);
    chk({tag, "_frame_start"}, {31'd0, frame_start}, 32'd0);
    chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_h_total"}, {20'd0, h_total}, 32'd0);
    chk({tag, "_h_active"}, {20'd0, h_active}, 32'd0);
    chk({tag, "_v_total"}, {21'd0, v_total}, 32'd0);
    chk({tag, "_v_active"}, {21'd0, v_active}, 32'd0);
  endtask

  // One raster frame; optional stretched line, alignment probes and mid-frame reset.
  task automatic drive_frame(input int vtot, input int stretch, input bit probe, input int rst_line);
    for (int v = 0; v < vtot; v++) begin
      int len;
      len = (v == stretch) ? H_TOT + 1 : H_TOT;
      for (int h = 0; h < len; h++) begin
        tick(!(h >= HS_BEG && h <= HS_END), !(v >= VS_BEG && v <= VS_END),
             (h >= H_ACT) || (v >= V_ACT));
        if (h == HS_BEG) last_hs_cyc = cyc;
        if (v == VS_BEG && h == 0) vs_cyc = cyc;
        if (v == stretch + 1 && h == HS_BEG) glitch_cyc = cyc;
        if (probe && v == 0 && h == 0) begin
          push(cyc + 2, 0, 32'd0);
          push(cyc + 2, 1, 32'd0);
          push(cyc + 2, 2, 32'd1);
          push(cyc + 2, 3, 32'd1);
        end
        if (probe && v == V_ACT - 1 && h == H_ACT - 1) begin
          push(cyc + 2, 0, 32'(H_ACT - 1));
          push(cyc + 2, 1, 32'(V_ACT - 1));
          push(cyc + 2, 2, 32'd1);
          push(cyc + 2, 3, 32'd0);
        end
        if (probe && v == V_ACT - 1 && h == H_ACT) begin
          push(cyc + 2, 2, 32'd0);
        end
        if (v == rst_line && h == 0) begin
          reset_n = 1'b0;
          #1;
          all_zero("midrst");
        end
        if (v == rst_line && h == 3) begin
          reset_n = 1'b1;
          rel_err = err_cnt;
          rel_fs  = fs_cnt;
        end
      end
    end
  endtask

  initial begin
    int vs2, hs_ref, e0;
    reset_n = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    blank = 1'b1;
    repeat (3) tick(1'b1, 1'b1, 1'b1);
    all_zero("reset");
    reset_n = 1'b1;
    repeat (2) tick(1'b1, 1'b1, 1'b1);

    // Nominal lock: vsync #1 in frame 0, lock two cycles after vsync #3 (frame 2).
    drive_frame(V_TOT0, -1, 1'b0, -1);
    drive_frame(V_TOT0, -1, 1'b1, -1);
    drive_frame(V_TOT0, -1, 1'b1, -1);
    vs2 = vs_cyc;
    drive_frame(V_TOT0, -1, 1'b1, -1);
    chk("lock_rise_cycle", rise_cyc, vs2 + 2);
    chk("locked_nominal", {31'd0, locked}, 32'd1);
    chk("h_total", {20'd0, h_total}, 32'(H_TOT));
    chk("h_active", {20'd0, h_active}, 32'(H_ACT));
    chk("v_total", {21'd0, v_total}, 32'(V_TOT0));
    chk("v_active", {21'd0, v_active}, 32'(V_ACT));
    chk("errors_nominal", err_cnt, 0);

    // Line glitch: one line one clock longer while locked.
    e0 = err_cnt;
    drive_frame(V_TOT0, 5, 1'b1, -1);
    chk("glitch_error_count", err_cnt - e0, 1);
    chk("glitch_error_cycle", last_err_cyc, glitch_cyc + 2);
    chk("glitch_lock_fall", fall_cyc, glitch_cyc + 2);
    drive_frame(V_TOT0, -1, 1'b1, -1);
    drive_frame(V_TOT0, -1, 1'b1, -1);
    chk("glitch_relock_cycle", rise_cyc, vs_cyc + 2);
    chk("glitch_error_total", err_cnt - e0, 1);

    // Sync loss: hsync held high until the line counter saturates.
    e0 = err_cnt;
    hs_ref = last_hs_cyc;
    repeat (4200) tick(1'b1, 1'b1, 1'b1);
    chk("timeout_error_count", err_cnt - e0, 1);
    chk("timeout_error_cycle", last_err_cyc, hs_ref + 4096);
    chk("timeout_lock_fall", fall_cyc, hs_ref + 4096);
    chk("timeout_locked", {31'd0, locked}, 32'd0);
    chk("timeout_h_total", {20'd0, h_total}, 32'(H_TOT));
    chk("timeout_h_active", {20'd0, h_active}, 32'(H_ACT));
    chk("timeout_v_total", {21'd0, v_total}, 32'(V_TOT0));
    chk("timeout_v_active", {21'd0, v_active}, 32'(V_ACT));

    // Reset mid-frame, then reacquire on the third vsync after release.
    drive_frame(V_TOT0, -1, 1'b0, 6);
    chk("postrst_no_error", err_cnt, rel_err);
    chk("postrst_no_frame_start", fs_cnt, rel_fs);
    chk("postrst_locked", {31'd0, locked}, 32'd0);
    drive_frame(V_TOT0, -1, 1'b1, -1);
    drive_frame(V_TOT0, -1, 1'b1, -1);
    chk("postrst_relock_cycle", rise_cyc, vs_cyc + 2);
    chk("postrst_errors", err_cnt, rel_err);

    // Frame-size change to V_TOT1 lines; the first short interval closes in frame 11.
    e0 = err_cnt;
    drive_frame(V_TOT1, -1, 1'b1, -1);
    drive_frame(V_TOT1, -1, 1'b1, -1);
    chk("resize_error_cycle", last_err_cyc, vs_cyc + 2);
    chk("resize_v_total", {21'd0, v_total}, 32'(V_TOT1));
    drive_frame(V_TOT1, -1, 1'b1, -1);
    drive_frame(V_TOT1, -1, 1'b1, -1);
    chk("resize_relock_cycle", rise_cyc, vs_cyc + 2);
    chk("resize_error_count", err_cnt - e0, 1);
    chk("resize_locked", {31'd0, locked}, 32'd1);
    chk("resize_v_active", {21'd0, v_active}, 32'(V_ACT));

    repeat (4) tick(1'b1, 1'b1, 1'b1);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
